// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: sequential neuron, one shared signed MAC per cycle, bias + threshold/clamp activation.
//   clk, rst_n         clock; synchronous active-low reset
//   i_in_data          N_IN packed signed inputs, element i at [i*DW +: DW]
//   i_in_weight        N_IN+1 packed signed weights, element N_IN is the bias
//   i_in_valid         input vector valid; o_in_ready high only in IDLE
//   o_out_data         activation result; o_out_valid held until i_out_ready
//   o_busy             high while computing or presenting a result
//   NEURON_SAT_ACC_EN  defined: accumulator saturates; undefined: accumulator wraps
module neuron_mac_seq #(
  parameter int N_IN = 32,
  parameter int DW = 32,
  parameter int ACC_W = 64,
  parameter int SHIFT = 0,
  parameter logic signed [ACC_W-1:0] THRESH = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_IN*DW-1:0]       i_in_data,
  input  logic [(N_IN+1)*DW-1:0]   i_in_weight,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  output logic [DW-1:0]            o_out_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic                     o_busy
);
  localparam int IW = $clog2(N_IN) + 1;
  localparam logic signed [ACC_W-1:0] MAXP = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t                   r_state;
  logic [IW-1:0]            r_idx;
  logic signed [ACC_W-1:0]  r_acc;
  logic [N_IN*DW-1:0]       r_in;
  logic [N_IN*DW-1:0]       r_w;
  logic [DW-1:0]            r_out;
  logic                     r_out_valid;
  logic signed [2*DW-1:0]   w_prod;
  logic signed [ACC_W-1:0]  w_a, w_b, w_next, w_y;
  logic [DW-1:0]            w_out;
  logic                     w_last;
  // The single adder serves both the bias load (0 + bias) in IDLE and each MAC step.
  always_comb begin
    w_prod = $signed(r_in[r_idx*DW +: DW]) * $signed(r_w[r_idx*DW +: DW]);
    w_a    = (r_state == IDLE) ? '0 : r_acc;
    w_b    = (r_state == IDLE) ? ACC_W'($signed(i_in_weight[N_IN*DW +: DW])) : ACC_W'(w_prod);
  end
`ifdef NEURON_SAT_ACC_EN
  logic [ACC_W:0] w_sum;
  // One guard bit: overflow when the two top bits disagree; guard bit gives the direction.
  always_comb begin
    w_sum  = {w_a[ACC_W-1], w_a} + {w_b[ACC_W-1], w_b};
    w_next = (w_sum[ACC_W] != w_sum[ACC_W-1]) ?
             (w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}}) :
             w_sum[ACC_W-1:0];
  end
`else
  assign w_next = w_a + w_b;
`endif
  // Activation is evaluated on the final sum so the result registers on the last MAC edge.
  always_comb begin
    w_y    = w_next >>> SHIFT;
    w_out  = (w_next < THRESH || w_y < 0) ? '0 : (w_y > MAXP) ? MAXP[DW-1:0] : w_y[DW-1:0];
    w_last = r_idx == IW'(N_IN - 1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_acc       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (r_state == IDLE && i_in_valid) begin
      r_in    <= i_in_data;
      r_w     <= i_in_weight[N_IN*DW-1:0];
      r_acc   <= w_next;
      r_idx   <= '0;
      r_state <= MAC;
    end else if (r_state == MAC) begin
      r_acc <= w_next;
      r_idx <= w_last ? r_idx : r_idx + 1'b1;
      if (w_last) begin
        r_state     <= OUT;
        r_out       <= w_out;
        r_out_valid <= 1'b1;
      end
    end else if (r_state == OUT && i_out_ready) begin
      r_out_valid <= 1'b0;
      r_state     <= IDLE;
    end
  end
  assign o_in_ready  = rst_n && r_state == IDLE;
  assign o_busy      = r_state != IDLE;
  assign o_out_data  = r_out;
  assign o_out_valid = r_out_valid;
endmodule

// File: tb/tb_neuron_mac_seq.sv
// tb_neuron_mac_seq: two neuron instances (wide and narrow accumulator) against an arithmetic reference model.
module tb_neuron_mac_seq;
  localparam int N = 4;
`ifdef NEURON_SAT_ACC_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic [39:0] in_weight = '0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic rdy_a, rdy_b, val_a, val_b, busy_a, busy_b;
  logic [7:0] out_a, out_b;
  int total = 0;
  int bad = 0;
  int in_v[4];
  int w_v[5];
  always #5 clk = ~clk;
  neuron_mac_seq #(.N_IN(N), .DW(8), .ACC_W(24), .SHIFT(0), .THRESH(24'sd0)) u_a (
    .clk(clk), .rst_n(rst_n), .i_in_data(in_data), .i_in_weight(in_weight),
    .i_in_valid(in_valid), .o_in_ready(rdy_a), .o_out_data(out_a), .o_out_valid(val_a),
    .i_out_ready(out_ready), .o_busy(busy_a));
  neuron_mac_seq #(.N_IN(N), .DW(8), .ACC_W(16), .SHIFT(3), .THRESH(-16'sd100)) u_b (
    .clk(clk), .rst_n(rst_n), .i_in_data(in_data), .i_in_weight(in_weight),
    .i_in_valid(in_valid), .o_in_ready(rdy_b), .o_out_data(out_b), .o_out_valid(val_b),
    .i_out_ready(out_ready), .o_busy(busy_b));
  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int model(input int accw, input int sh, input longint th);
    longint a, mx, y;
    mx = (longint'(1) <<< (accw - 1)) - 1;
    a = w_v[4];
    for (int i = 0; i < 4; i++) begin
      a = a + in_v[i] * w_v[i];
      if (SAT) a = (a > mx) ? mx : (a < -mx - 1) ? -mx - 1 : a;
      else a = (a <<< (64 - accw)) >>> (64 - accw);
    end
    y = a >>> sh;
    return (a < th || y < 0) ? 0 : (y > 127) ? 127 : int'(y);
  endfunction
  task automatic pack();
    for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = in_v[i][7:0];
    for (int i = 0; i < 5; i++) in_weight[i*8 +: 8] = w_v[i][7:0];
  endtask
  task automatic run_vec(input int hold, input string tag);
    int ea, eb;
    ea = model(24, 0, 0);
    eb = model(16, 3, -100);
    pack();
    in_valid = 1'b1;
    out_ready = 1'b0;
    check({tag, "_rdy_idle"}, rdy_a, 1);
    @(posedge clk); #1;
    in_data = $urandom;
    in_weight = {$urandom, 8'($urandom)};
    out_ready = 1'b1;
    check({tag, "_busy_mac"}, busy_a, 1);
    check({tag, "_rdy_mac"}, rdy_b, 0);
    repeat (N - 1) @(posedge clk);
    #1;
    check({tag, "_early_valid"}, val_a, 0);
    @(posedge clk); #1;
    check({tag, "_valid_a"}, val_a, 1);
    check({tag, "_valid_b"}, val_b, 1);
    check({tag, "_out_a"}, out_a, ea);
    check({tag, "_out_b"}, out_b, eb);
    if (hold > 0) out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, val_a, 1);
      check({tag, "_hold_out"}, out_a, ea);
      check({tag, "_hold_rdy"}, rdy_a, 0);
      check({tag, "_hold_busy"}, busy_b, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check({tag, "_done_valid"}, val_b, 0);
    check({tag, "_done_rdy"}, rdy_a, 1);
    check({tag, "_done_busy"}, busy_a, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", val_a, 0);
    check("rst_out", out_a, 0);
    check("rst_rdy", rdy_a, 0);
    check("rst_busy", busy_a, 0);
    rst_n = 1'b1;
    #1;
    check("rel_rdy", rdy_b, 1);
    in_v = '{1, 2, 3, 4};       w_v = '{1, 1, 1, 1, 5};
    run_vec(0, "t1");
    check("t1_const", out_a, 15);
    in_v = '{-1, -2, -3, -4};   w_v = '{1, 1, 1, 1, 0};
    run_vec(0, "t2");
    in_v = '{127, 127, 127, 127}; w_v = '{127, 127, 127, 127, 0};
    run_vec(3, "t3");
    in_v = '{-128, -128, -128, -128}; w_v = '{-128, -128, -128, -128, 127};
    run_vec(1, "t_max");
    in_v = '{-128, 127, -128, 127}; w_v = '{127, -128, 127, -128, -128};
    run_vec(0, "t_min");
    in_v = '{1, 2, 3, 4};       w_v = '{1, 1, 1, 1, 5};
    pack();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_valid", val_a, 0);
    check("abort_out", out_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_rdy", rdy_a, 0);
    rst_n = 1'b1;
    #1;
    run_vec(0, "t5");
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) in_v[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < 5; i++) w_v[i] = int'($urandom_range(0, 255)) - 128;
      run_vec(int'($urandom_range(0, 2)), "rnd");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
